image_block_packer: RTL

IMAGE_BLOCK_PACKER -- requirements
Module: image_block_packer

---
 rtl/image_block_packer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/image_block_packer.sv
// Packs a byte stream into 128-bit plaintext blocks for a CBC encryptor, first byte in the MSBs.
// The final block is closed with PKCS#7 padding (PAD_EN=1) or zero-filled (PAD_EN=0).
module image_block_packer #(
    parameter int PAD_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [127:0] out_block,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready,
    output logic [15:0]  block_count
);

    typedef enum logic {S_FILL, S_PAD} state_t;

    state_t         state, state_next;
    logic [3:0]     cnt;
    logic [127:0]   acc;
    logic           completing, out_free, accept, load, load_last;
    logic [127:0]   merged, load_block;

    function automatic logic [127:0] place_byte(input logic [127:0] blk,
                                                input logic [3:0] pos,
                                                input logic [7:0] b);
        logic [127:0] r;
        r = blk;
        r[127 - 8 * int'(pos) -: 8] = b;
        return r;
    endfunction

    // Bytes after the one just written get the PKCS#7 count (remaining byte count) or zero.
    function automatic logic [127:0] pad_tail(input logic [127:0] blk,
                                              input logic [3:0] pos);
        logic [127:0] r;
        logic [7:0]   fill;
        r    = blk;
        fill = (PAD_EN != 0) ? {4'd0, 4'd15 - pos} : 8'h00;
        for (int k = 0; k < 16; k++) begin
            if (k > int'(pos)) r[127 - 8 * k -: 8] = fill;
        end
        return r;
    endfunction

    assign completing = (cnt == 4'd15) || in_last;
    assign out_free   = !out_valid || out_ready;
    assign in_ready   = (state == S_FILL) && !(completing && !out_free);
    assign accept     = in_valid && in_ready;
    assign merged     = place_byte(acc, cnt, in_byte);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FILL;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_block = merged;
        load_last  = 1'b0;
        case (state)
            S_FILL: begin
                if (accept && completing) begin
                    load = 1'b1;
                    if (cnt == 4'd15) begin
                        // A full final block under PKCS#7 still needs a whole pad block after it.
                        if (in_last && PAD_EN != 0) state_next = S_PAD;
                        else                         load_last  = in_last;
                    end else begin
                        load_block = pad_tail(merged, cnt);
                        load_last  = 1'b1;
                    end
                end
            end
            S_PAD: begin
                if (out_free) begin
                    load       = 1'b1;
                    load_block = {16{8'h10}};
                    load_last  = 1'b1;
                    state_next = S_FILL;
                end
            end
            default: state_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
            acc <= '0;
        end else if (accept) begin
            if (completing) begin
                cnt <= 4'd0;
                acc <= '0;
            end else begin
                cnt <= cnt + 4'd1;
                acc <= merged;
            end
        end
    end

    // A load on a consume edge replaces the departing block directly, so no bubble appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_block   <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            block_count <= 16'd0;
        end else begin
            if (load) begin
                out_block <= load_block;
                out_valid <= 1'b1;
                out_last  <= load_last;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) block_count <= block_count + 16'd1;
        end
    end

endmodule
